// File: rtl/trig_dly_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : trig_dly_pkg
//  Description : Shared defaults and helpers for the multi-channel trigger
//                delay / pulse stretcher (trig_delay_stretch, trig_dly_chan).
//                  DEF_*      default parameter values
//                  clamp_dly  limits a requested delay to the deepest tap
//                  popcount   counts set bits of a (zero-extended) vector
//  Revision    : 1.0  initial release
// ============================================================================
package trig_dly_pkg;

    localparam int DEF_N_CH    = 8;
    localparam int DEF_MAX_DLY = 15;
    localparam int DEF_DLY_W   = 4;
    localparam int DEF_WID_W   = 4;
    localparam int DEF_CNT_W   = 16;

    function automatic int clamp_dly(input int sel, input int max_dly);
        return (sel > max_dly) ? max_dly : sel;
    endfunction

    function automatic int popcount(input logic [63:0] v);
        int n;
        n = 0;
        for (int b = 0; b < 64; b++) begin
            n += int'(v[b]);
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/trig_dly_chan.sv
`default_nettype none
// ============================================================================
//  Module      : trig_dly_chan
//  Description : One trigger channel: rising-edge detect, delay pipe with a
//                runtime tap select, and a pulse stretch counter.
//  Ports       : clk, rst_n        clock / async active-low reset
//                trig_in           trigger level
//                enable, veto      edge insertion gate / synchronous flush
//                retrig_en         1 = reload width on a delayed edge during a
//                                  pulse, 0 = discard that edge (flag drop)
//                dly_act, wid_act  frozen delay tap and pulse width
//                trig_out          registered stretched pulse
//                active            event in the pipe or pulse in progress
//                drop              combinational: an event is discarded this cycle
//  Revision    : 1.0  initial release
// ============================================================================
module trig_dly_chan
    import trig_dly_pkg::*;
#(
    parameter int MAX_DLY = DEF_MAX_DLY,
    parameter int DLY_W   = DEF_DLY_W,
    parameter int WID_W   = DEF_WID_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             trig_in,
    input  logic             enable,
    input  logic             veto,
    input  logic             retrig_en,
    input  logic [DLY_W-1:0] dly_act,
    input  logic [WID_W-1:0] wid_act,
    output logic             trig_out,
    output logic             active,
    output logic             drop
);

    logic               trig_q, trig_d;
    logic [MAX_DLY:0]   pipe_q, pipe_d;
    logic [WID_W-1:0]   cnt_q, cnt_d;
    logic               trig_out_q, trig_out_d;
    logic               edge_det;
    logic               dlyd;

    always_comb begin
        trig_d   = trig_in;
        edge_det = trig_in & ~trig_q & enable & ~veto;
        pipe_d   = {pipe_q[MAX_DLY-1:0], edge_det};

        // Tap mux written as a compare loop so dly_act may be wider than the
        // tap index without reading past the pipe.
        dlyd = 1'b0;
        for (int j = 0; j <= MAX_DLY; j++) begin
            if (dly_act == DLY_W'(j)) begin
                dlyd = pipe_q[j];
            end
        end

        cnt_d = cnt_q;
        drop  = 1'b0;
        if (cnt_q != '0) begin
            cnt_d = cnt_q - WID_W'(1);
        end
        // cnt_q == 1 is still an active pulse, so an edge there is a
        // retrigger (or a drop), not a fresh start.
        if (dlyd) begin
            if ((cnt_q == '0) || retrig_en) begin
                cnt_d = wid_act;
            end else begin
                drop = 1'b1;
            end
        end

        // Veto wipes everything in flight; a discard in the same cycle is
        // not counted because the event is flushed anyway.
        if (veto) begin
            pipe_d = '0;
            cnt_d  = '0;
            drop   = 1'b0;
        end

        trig_out_d = (cnt_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_q     <= 1'b0;
            pipe_q     <= '0;
            cnt_q      <= '0;
            trig_out_q <= 1'b0;
        end else begin
            trig_q     <= trig_d;
            pipe_q     <= pipe_d;
            cnt_q      <= cnt_d;
            trig_out_q <= trig_out_d;
        end
    end

    assign trig_out = trig_out_q;
    assign active   = (|pipe_q) | (cnt_q != '0);

endmodule
`default_nettype wire

// File: rtl/trig_delay_stretch.sv
`default_nettype none
// ============================================================================
//  Module      : trig_delay_stretch
//  Description : Multi-channel trigger delay and pulse stretcher. Each channel
//                delays rising edges by a programmable tap and stretches them
//                into pulses of programmable width; discarded retriggers are
//                counted in a saturating counter.
//  Ports       : clk, rst_n   clock / async active-low reset
//                trig_in      [N_CH]  trigger levels
//                enable       accept new edges
//                veto         synchronous flush of all channels
//                retrig_en    extend (1) or drop (0) on retrigger
//                dly_sel      [DLY_W] requested delay, clamped to MAX_DLY
//                width        [WID_W] requested pulse width, 0 means 1
//                trig_out     [N_CH]  delayed, stretched pulses
//                busy         any channel has work in flight
//                drop_cnt     [CNT_W] saturating dropped-event count
//  Revision    : 1.0  initial release
// ============================================================================
module trig_delay_stretch
    import trig_dly_pkg::*;
#(
    parameter int N_CH    = DEF_N_CH,
    parameter int MAX_DLY = DEF_MAX_DLY,
    parameter int DLY_W   = DEF_DLY_W,
    parameter int WID_W   = DEF_WID_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  trig_in,
    input  logic             enable,
    input  logic             veto,
    input  logic             retrig_en,
    input  logic [DLY_W-1:0] dly_sel,
    input  logic [WID_W-1:0] width,
    output logic [N_CH-1:0]  trig_out,
    output logic             busy,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam int SUM_W = CNT_W + 8;

    logic [DLY_W-1:0] dly_act_q, dly_act_d;
    logic [WID_W-1:0] wid_act_q, wid_act_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [N_CH-1:0]  chan_active;
    logic [N_CH-1:0]  chan_drop;
    logic [SUM_W-1:0] drop_sum;

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        trig_dly_chan #(
            .MAX_DLY (MAX_DLY),
            .DLY_W   (DLY_W),
            .WID_W   (WID_W)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .trig_in   (trig_in[i]),
            .enable    (enable),
            .veto      (veto),
            .retrig_en (retrig_en),
            .dly_act   (dly_act_q),
            .wid_act   (wid_act_q),
            .trig_out  (trig_out[i]),
            .active    (chan_active[i]),
            .drop      (chan_drop[i])
        );
    end

    assign busy = |chan_active;

    always_comb begin
        // Config only follows the inputs while idle, so an event already in
        // a pipe always leaves through the tap it entered with.
        if (busy) begin
            dly_act_d = dly_act_q;
            wid_act_d = wid_act_q;
        end else begin
            dly_act_d = DLY_W'(clamp_dly(int'(dly_sel), MAX_DLY));
            wid_act_d = (width == '0) ? WID_W'(1) : width;
        end

        // Extra headroom bits make overflow visible before clamping.
        drop_sum = SUM_W'(drop_cnt_q) + SUM_W'(popcount(64'(chan_drop)));
        if (drop_sum[SUM_W-1:CNT_W] != '0) begin
            drop_cnt_d = '1;
        end else begin
            drop_cnt_d = drop_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly_act_q  <= '0;
            wid_act_q  <= WID_W'(1);
            drop_cnt_q <= '0;
        end else begin
            dly_act_q  <= dly_act_d;
            wid_act_q  <= wid_act_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_trig_delay_stretch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_trig_delay_stretch
//  Description : Self-checking bench for trig_delay_stretch. An event-list
//                model (insertion times, remaining pulse cycles) predicts the
//                outputs every cycle; directed scenarios add literal checks.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_trig_delay_stretch;

    localparam int N_CH    = 8;
    localparam int MAX_DLY = 15;
    localparam int DLY_W   = 5;
    localparam int WID_W   = 4;
    localparam int CNT_W   = 16;
    localparam int CNT_MAX = 65535;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N_CH-1:0]  trig_in = '0;
    logic             enable = 1'b1;
    logic             veto = 1'b0;
    logic             retrig_en = 1'b0;
    logic [DLY_W-1:0] dly_sel = '0;
    logic [WID_W-1:0] width = '0;
    logic [N_CH-1:0]  trig_out;
    logic             busy;
    logic [CNT_W-1:0] drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    trig_delay_stretch #(
        .N_CH    (N_CH),
        .MAX_DLY (MAX_DLY),
        .DLY_W   (DLY_W),
        .WID_W   (WID_W),
        .CNT_W   (CNT_W)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .trig_in   (trig_in),
        .enable    (enable),
        .veto      (veto),
        .retrig_en (retrig_en),
        .dly_sel   (dly_sel),
        .width     (width),
        .trig_out  (trig_out),
        .busy      (busy),
        .drop_cnt  (drop_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: every accepted edge is an (channel, insertion cycle) entry.
    // It fires dly+1 cycles after insertion and occupies the channel until
    // MAX_DLY+1 cycles have passed. Pulses are remaining-cycle counts.
    // ------------------------------------------------------------------
    typedef struct {
        int ch;
        int t;
    } ev_t;

    ev_t             m_ev[$];
    int              m_rem[N_CH];
    int              m_dly;
    int              m_wid;
    int              m_drop;
    int              m_cyc;
    logic [N_CH-1:0] m_prev;

    function automatic bit m_busy();
        bit b;
        b = (m_ev.size() != 0);
        for (int c = 0; c < N_CH; c++) begin
            if (m_rem[c] != 0) b = 1'b1;
        end
        return b;
    endfunction

    task automatic m_reset();
        m_ev.delete();
        for (int c = 0; c < N_CH; c++) m_rem[c] = 0;
        m_dly  = 0;
        m_wid  = 1;
        m_drop = 0;
        m_cyc  = 0;
        m_prev = '0;
    endtask

    task automatic m_step();
        ev_t keep[$];
        bit  busy_pre;
        bit  fire[N_CH];
        int  ndrop;
        busy_pre = m_busy();
        ndrop = 0;
        if (veto) begin
            m_ev.delete();
            for (int c = 0; c < N_CH; c++) m_rem[c] = 0;
        end else begin
            for (int c = 0; c < N_CH; c++) fire[c] = 1'b0;
            foreach (m_ev[i]) begin
                if (m_ev[i].t + m_dly + 1 == m_cyc) fire[m_ev[i].ch] = 1'b1;
            end
            for (int c = 0; c < N_CH; c++) begin
                if (fire[c]) begin
                    if (m_rem[c] == 0 || retrig_en) begin
                        m_rem[c] = m_wid;
                    end else begin
                        ndrop++;
                        m_rem[c] = m_rem[c] - 1;
                    end
                end else if (m_rem[c] > 0) begin
                    m_rem[c] = m_rem[c] - 1;
                end
            end
            m_drop = (m_drop + ndrop > CNT_MAX) ? CNT_MAX : m_drop + ndrop;
            foreach (m_ev[i]) begin
                if (m_cyc - m_ev[i].t <= MAX_DLY) keep.push_back(m_ev[i]);
            end
            m_ev = keep;
            for (int c = 0; c < N_CH; c++) begin
                if (trig_in[c] && !m_prev[c] && enable) begin
                    ev_t e;
                    e.ch = c;
                    e.t  = m_cyc;
                    m_ev.push_back(e);
                end
            end
        end
        if (!busy_pre) begin
            m_dly = (int'(dly_sel) > MAX_DLY) ? MAX_DLY : int'(dly_sel);
            m_wid = (width == '0) ? 1 : int'(width);
        end
        m_prev = trig_in;
        m_cyc++;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m_reset();
            else        m_step();
        end
    end

    task automatic compare_cycle();
        logic [N_CH-1:0] exp_out;
        for (int c = 0; c < N_CH; c++) exp_out[c] = (m_rem[c] != 0);
        check("cyc_trig_out", 32'(trig_out), 32'(exp_out));
        check("cyc_busy", 32'(busy), 32'(m_busy()));
        check("cyc_drop_cnt", 32'(drop_cnt), 32'(m_drop));
    endtask

    always @(negedge clk) compare_cycle();

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic drv(input logic [N_CH-1:0] t);
        @(negedge clk);
        trig_in = t;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait", 32'(busy), 32'(0));
    endtask

    task automatic count_high(input int ncyc, input logic [N_CH-1:0] mask, output int hits);
        hits = 0;
        repeat (ncyc) begin
            @(posedge clk);
            #1;
            if ((trig_out & mask) != '0) hits++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hits;

        // Reset state
        dly_sel = 5'd3;
        width   = 4'd2;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_trig_out", 32'(trig_out), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_drop_cnt", 32'(drop_cnt), 32'(0));

        // 1: delay 3, width 2 on ch0
        drv('0);
        drv('0);
        drv(8'h01);
        repeat (4) @(posedge clk);
        #1 check("t1_k3_low", 32'(trig_out), 32'h00);
        @(posedge clk);
        #1 check("t1_k4", 32'(trig_out), 32'h01);
        @(posedge clk);
        #1 check("t1_k5", 32'(trig_out), 32'h01);
        @(posedge clk);
        #1 check("t1_k6", 32'(trig_out), 32'h00);
        check("t1_drop", 32'(drop_cnt), 32'(0));

        // 2: delay 0 / width 0, then max delay, then clamped delay
        drv('0);
        wait_idle();
        dly_sel = 5'd0;
        width   = 4'd0;
        drv('0);
        drv(8'h01);
        repeat (2) @(posedge clk);
        #1 check("t2_d0_k1", 32'(trig_out), 32'h01);
        @(posedge clk);
        #1 check("t2_d0_k2", 32'(trig_out), 32'h00);
        for (int s = 0; s < 2; s++) begin
            drv('0);
            wait_idle();
            dly_sel = (s == 0) ? 5'd15 : 5'd20;
            drv('0);
            drv(8'h01);
            repeat (16) @(posedge clk);
            #1 check("t2_dmax_k15", 32'(trig_out), 32'h00);
            @(posedge clk);
            #1 check("t2_dmax_k16", 32'(trig_out), 32'h01);
            @(posedge clk);
            #1 check("t2_dmax_k17", 32'(trig_out), 32'h00);
        end

        // 3: two edges two cycles apart, retrigger then drop
        for (int r = 1; r >= 0; r--) begin
            drv('0);
            wait_idle();
            dly_sel   = 5'd2;
            width     = 4'd4;
            retrig_en = (r == 1);
            drv('0);
            drv(8'h01);
            drv(8'h00);
            drv(8'h01);
            count_high(14, 8'h01, hits);
            check(r ? "t3_retrig_len" : "t3_drop_len", 32'(hits), r ? 32'd6 : 32'd4);
        end
        check("t3_drop_cnt", 32'(drop_cnt), 32'd1);
        check("t3_model_drop", 32'(m_drop), 32'd1);

        // 4: all channels drop together, then saturate the counter
        drv('0);
        wait_idle();
        dly_sel   = 5'd0;
        width     = 4'd4;
        retrig_en = 1'b0;
        drv('0);
        drv(8'hFF);
        drv(8'h00);
        drv(8'hFF);
        repeat (4) @(posedge clk);
        #1 check("t4_drop8", 32'(drop_cnt), 32'd9);
        check("t4_model_drop8", 32'(m_drop), 32'd9);
        drv('0);
        wait_idle();
        width = 4'd15;
        for (int i = 0; i < 19500; i++) begin
            drv((i % 2 == 0) ? 8'hFF : 8'h00);
        end
        drv('0);
        wait_idle();
        check("t4_saturate", 32'(drop_cnt), 32'hFFFF);
        check("t4_model_sat", 32'(m_drop), 32'd65535);

        // 5: veto with three events in flight; level high across veto
        dly_sel   = 5'd6;
        width     = 4'd2;
        retrig_en = 1'b1;
        drv('0);
        drv(8'h01);
        drv(8'h00);
        drv(8'h01);
        drv(8'h00);
        drv(8'h01);
        @(negedge clk);
        veto    = 1'b1;
        trig_in = 8'h09;
        @(negedge clk);
        veto = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("t5_busy_after_veto", 32'(busy), 32'(0));
        count_high(20, 8'hFF, hits);
        check("t5_no_pulse", 32'(hits), 32'(0));

        // enable low: edges neither inserted nor counted
        drv('0);
        enable = 1'b0;
        drv(8'h02);
        count_high(12, 8'hFF, hits);
        check("en0_no_pulse", 32'(hits), 32'(0));
        check("en0_busy", 32'(busy), 32'(0));
        enable = 1'b1;

        // 6: delay change while busy, then async reset mid-pulse
        drv('0);
        wait_idle();
        dly_sel = 5'd2;
        width   = 4'd2;
        drv('0);
        drv(8'h01);
        @(negedge clk);
        dly_sel = 5'd6;
        repeat (3) @(posedge clk);
        #1 check("t6_old_dly", 32'(trig_out), 32'h01);
        drv('0);
        wait_idle();
        drv('0);
        drv(8'h01);
        repeat (7) @(posedge clk);
        #1 check("t6_new_dly_k6", 32'(trig_out), 32'h00);
        @(posedge clk);
        #1 check("t6_new_dly_k7", 32'(trig_out), 32'h01);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_trig_out", 32'(trig_out), 32'h00);
        check("t6_rst_busy", 32'(busy), 32'(0));
        check("t6_rst_drop", 32'(drop_cnt), 32'(0));
        trig_in = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        count_high(20, 8'hFF, hits);
        check("t6_no_resume", 32'(hits), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
